// File: rtl/local_store_responder_if.sv
// Bus between the odd pipe / fetch front end (master) and the local-store responder (slave).
// Carries the data port, the instruction-fetch port and the error flag.
interface local_store_responder_if #(
    parameter int LS_ADDR_WIDTH = 15
);
    logic [LS_ADDR_WIDTH-1:0] LS_address_input;
    logic [127:0]             LS_data_input;
    logic                     LS_wrt_en;
    logic                     LS_rd_en;
    logic [127:0]             LS_data_output;
    logic                     load_valid;
    logic                     fetch_req;
    logic [31:0]              fetch_address;
    logic                     fetch_grant;
    logic [127:0]             fetch_data;
    logic                     fetch_valid;
    logic                     collision_err;

    modport master (
        output LS_address_input,
        output LS_data_input,
        output LS_wrt_en,
        output LS_rd_en,
        input  LS_data_output,
        input  load_valid,
        output fetch_req,
        output fetch_address,
        input  fetch_grant,
        input  fetch_data,
        input  fetch_valid,
        input  collision_err
    );

    modport slave (
        input  LS_address_input,
        input  LS_data_input,
        input  LS_wrt_en,
        input  LS_rd_en,
        output LS_data_output,
        output load_valid,
        input  fetch_req,
        input  fetch_address,
        output fetch_grant,
        output fetch_data,
        output fetch_valid,
        output collision_err
    );
endinterface

// File: rtl/local_store_responder.sv
// SPU local store: one single-ported quadword array shared by the odd-pipe data port
// (high priority) and the instruction-fetch port, each with its own fixed-latency return pipe.
module local_store_responder #(
    parameter int LS_ADDR_WIDTH = 15,
    parameter int LOAD_LATENCY  = 6,
    parameter int FETCH_LATENCY = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    local_store_responder_if.slave ls
);
    localparam int IDX_W = LS_ADDR_WIDTH - 4;
    localparam int DEPTH = 1 << IDX_W;

    logic [127:0] mem [DEPTH];

    logic [IDX_W-1:0] ls_idx;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] port_idx;
    logic             data_port_busy;
    logic             store_acc;
    logic             load_acc;
    logic             fetch_acc;
    logic             collision;
    logic             collision_err_reg;

    // Quadword index is the top of the byte address; fetch uses PC bits [14:4].
    always_comb begin
        ls_idx         = ls.LS_address_input[LS_ADDR_WIDTH-1 -: IDX_W];
        fetch_idx      = ls.fetch_address[IDX_W+3:4];
        data_port_busy = ls.LS_wrt_en | ls.LS_rd_en;
        store_acc      = ls.LS_wrt_en & ~reset;
        load_acc       = ls.LS_rd_en & ~ls.LS_wrt_en & ~reset;
        fetch_acc      = ls.fetch_req & ~data_port_busy & ~reset;
        collision      = ls.LS_wrt_en & ls.LS_rd_en;
        port_idx       = data_port_busy ? ls_idx : fetch_idx;
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ls.fetch_address[31:IDX_W+4], ls.fetch_address[3:0],
                                ls.LS_address_input[3:0]};

    always_ff @(posedge clock) begin
        if (store_acc) begin
            mem[port_idx] <= ls.LS_data_input;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            collision_err_reg <= 1'b0;
        end else if (collision) begin
            collision_err_reg <= 1'b1;
        end
    end

    // Load return pipe. Stage 0 is the array's registered read; every stage only
    // captures data alongside a valid, so the last stage holds its last returned value.
    genvar gi;
    generate
        for (gi = 0; gi < LOAD_LATENCY; gi++) begin : g_load_stage
            logic         vld_reg;
            logic [127:0] dat_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clock) begin
                    if (reset) begin
                        vld_reg <= 1'b0;
                        dat_reg <= '0;
                    end else begin
                        vld_reg <= load_acc;
                        if (load_acc) begin
                            dat_reg <= mem[port_idx];
                        end
                    end
                end
            end else begin : g_body
                always_ff @(posedge clock) begin
                    if (reset) begin
                        vld_reg <= 1'b0;
                        dat_reg <= '0;
                    end else begin
                        vld_reg <= g_load_stage[gi-1].vld_reg;
                        if (g_load_stage[gi-1].vld_reg) begin
                            dat_reg <= g_load_stage[gi-1].dat_reg;
                        end
                    end
                end
            end
        end
    endgenerate

    // Fetch return pipe, independent of the load pipe; shares only the array read port.
    generate
        for (gi = 0; gi < FETCH_LATENCY; gi++) begin : g_fetch_stage
            logic         vld_reg;
            logic [127:0] dat_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clock) begin
                    if (reset) begin
                        vld_reg <= 1'b0;
                        dat_reg <= '0;
                    end else begin
                        vld_reg <= fetch_acc;
                        if (fetch_acc) begin
                            dat_reg <= mem[port_idx];
                        end
                    end
                end
            end else begin : g_body
                always_ff @(posedge clock) begin
                    if (reset) begin
                        vld_reg <= 1'b0;
                        dat_reg <= '0;
                    end else begin
                        vld_reg <= g_fetch_stage[gi-1].vld_reg;
                        if (g_fetch_stage[gi-1].vld_reg) begin
                            dat_reg <= g_fetch_stage[gi-1].dat_reg;
                        end
                    end
                end
            end
        end
    endgenerate

    assign ls.fetch_grant    = fetch_acc;
    assign ls.load_valid     = g_load_stage[LOAD_LATENCY-1].vld_reg;
    assign ls.LS_data_output = g_load_stage[LOAD_LATENCY-1].dat_reg;
    assign ls.fetch_valid    = g_fetch_stage[FETCH_LATENCY-1].vld_reg;
    assign ls.fetch_data     = g_fetch_stage[FETCH_LATENCY-1].dat_reg;
    assign ls.collision_err  = collision_err_reg;

endmodule

// File: tb/tb_local_store_responder.sv
// Scoreboard bench for local_store_responder: expected returns (data and due cycle)
// are queued when requests are driven and checked when the valids fire.
module tb_local_store_responder;
    localparam int LOAD_LAT  = 6;
    localparam int FETCH_LAT = 2;

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t load_q[$];
    exp_t fetch_q[$];
    exp_t mon_load_e;
    exp_t mon_fetch_e;
    logic [127:0] model_mem [2048];

    local_store_responder_if #(.LS_ADDR_WIDTH(15)) bus ();

    local_store_responder #(
        .LS_ADDR_WIDTH(15),
        .LOAD_LATENCY (LOAD_LAT),
        .FETCH_LATENCY(FETCH_LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ls   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Response monitor: every valid must match the oldest expectation, in data and cycle.
    always @(negedge clock) begin
        if (bus.load_valid === 1'b1) begin
            n_checks++;
            if (load_q.size() == 0) begin
                n_fail++;
                $display("FAIL load_unexpected: load_valid=1 data=%h at cycle %0d, required no response",
                         bus.LS_data_output, cyc);
            end else begin
                mon_load_e = load_q.pop_front();
                if (bus.LS_data_output !== mon_load_e.data || cyc != mon_load_e.due) begin
                    n_fail++;
                    $display("FAIL load_return: got %h at cycle %0d, required %h at cycle %0d",
                             bus.LS_data_output, cyc, mon_load_e.data, mon_load_e.due);
                end else begin
                    $display("load  return data=%h cycle=%0d", bus.LS_data_output, cyc);
                end
            end
        end
        if (bus.fetch_valid === 1'b1) begin
            n_checks++;
            if (fetch_q.size() == 0) begin
                n_fail++;
                $display("FAIL fetch_unexpected: fetch_valid=1 data=%h at cycle %0d, required no response",
                         bus.fetch_data, cyc);
            end else begin
                mon_fetch_e = fetch_q.pop_front();
                if (bus.fetch_data !== mon_fetch_e.data || cyc != mon_fetch_e.due) begin
                    n_fail++;
                    $display("FAIL fetch_return: got %h at cycle %0d, required %h at cycle %0d",
                             bus.fetch_data, cyc, mon_fetch_e.data, mon_fetch_e.due);
                end else begin
                    $display("fetch return data=%h cycle=%0d", bus.fetch_data, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic drive_idle();
        bus.LS_wrt_en = 1'b0;
        bus.LS_rd_en  = 1'b0;
        bus.fetch_req = 1'b0;
    endtask

    task automatic drive_store(input logic [14:0] addr, input logic [127:0] data);
        bus.LS_wrt_en        = 1'b1;
        bus.LS_rd_en         = 1'b0;
        bus.LS_address_input = addr;
        bus.LS_data_input    = data;
        if (!reset) model_mem[addr[14:4]] = data;
        $display("store addr=%h data=%h cycle=%0d reset=%0b", addr, data, cyc, reset);
    endtask

    task automatic drive_load(input logic [14:0] addr);
        bus.LS_wrt_en        = 1'b0;
        bus.LS_rd_en         = 1'b1;
        bus.LS_address_input = addr;
        load_q.push_back('{data: model_mem[addr[14:4]], due: cyc + LOAD_LAT});
        $display("load  addr=%h cycle=%0d", addr, cyc);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30; i++) begin
            if (load_q.size() == 0 && fetch_q.size() == 0) break;
            tick();
        end
    endtask

    task automatic test_reset();
        bus.fetch_req     = 1'b1;
        bus.fetch_address = 32'h0;
        bus.LS_wrt_en     = 1'b0;
        bus.LS_rd_en      = 1'b0;
        bus.LS_address_input = '0;
        bus.LS_data_input    = '0;
        tick();
        tick();
        #1;
        n_checks++;
        if (bus.fetch_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_grant: fetch_grant=%b, required 0", bus.fetch_grant);
        end
        n_checks++;
        if (bus.load_valid !== 1'b0 || bus.fetch_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valids: load_valid=%b fetch_valid=%b, required 0 0",
                     bus.load_valid, bus.fetch_valid);
        end
        n_checks++;
        if (bus.LS_data_output !== 128'h0 || bus.fetch_data !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: LS_data_output=%h fetch_data=%h, required 0",
                     bus.LS_data_output, bus.fetch_data);
        end
        n_checks++;
        if (bus.collision_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_collision: collision_err=%b, required 0", bus.collision_err);
        end
        $display("reset checked cycle=%0d", cyc);
        tick();
        reset = 1'b0;
        drive_idle();
    endtask

    task automatic test_store_load();
        tick();
        drive_store(15'h0040, 128'hDEAD_BEEF);
        tick();
        drive_load(15'h004F);
        tick();
        drive_idle();
        wait_drain();
        n_checks++;
        if (load_q.size() != 0) begin
            n_fail++;
            $display("FAIL store_load_drain: %0d loads outstanding, required 0", load_q.size());
        end
    endtask

    task automatic test_pipelined();
        tick(); drive_store(15'h0000, 128'h1);
        tick(); drive_store(15'h0010, 128'h2);
        tick(); drive_store(15'h0020, 128'h3);
        tick(); drive_store(15'h7FFF, 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F);
        tick(); drive_load(15'h0000);
        tick(); drive_load(15'h0010);
        tick(); drive_load(15'h0020);
        tick(); drive_load(15'h7FF0);
        tick(); drive_idle();
        wait_drain();
        n_checks++;
        if (load_q.size() != 0) begin
            n_fail++;
            $display("FAIL pipelined_drain: %0d loads outstanding, required 0", load_q.size());
        end
    endtask

    task automatic test_arbitration();
        tick();
        drive_store(15'h0200, 128'h0BAD_F00D);
        bus.fetch_req     = 1'b1;
        bus.fetch_address = 32'h0000_0040;
        #1;
        n_checks++;
        if (bus.fetch_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL grant_vs_store: fetch_grant=%b, required 0", bus.fetch_grant);
        end
        tick();
        drive_load(15'h0200);
        #1;
        n_checks++;
        if (bus.fetch_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL grant_vs_load: fetch_grant=%b, required 0", bus.fetch_grant);
        end
        tick();
        drive_idle();
        bus.fetch_req = 1'b1;
        #1;
        n_checks++;
        if (bus.fetch_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL grant_idle: fetch_grant=%b, required 1", bus.fetch_grant);
        end
        fetch_q.push_back('{data: model_mem[11'h004], due: cyc + FETCH_LAT});
        $display("fetch pc=%h cycle=%0d", bus.fetch_address, cyc);
        tick();
        bus.fetch_req = 1'b0;
        wait_drain();
        n_checks++;
        if (load_q.size() != 0 || fetch_q.size() != 0) begin
            n_fail++;
            $display("FAIL arbitration_drain: loads=%0d fetches=%0d outstanding, required 0 0",
                     load_q.size(), fetch_q.size());
        end
    endtask

    task automatic test_collision();
        tick();
        n_checks++;
        if (bus.collision_err !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_before: collision_err=%b, required 0", bus.collision_err);
        end
        bus.LS_wrt_en        = 1'b1;
        bus.LS_rd_en         = 1'b1;
        bus.LS_address_input = 15'h0100;
        bus.LS_data_input    = 128'h5;
        model_mem[11'h010]   = 128'h5;
        $display("collide addr=0100 data=5 cycle=%0d", cyc);
        tick();
        drive_idle();
        n_checks++;
        if (bus.collision_err !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_set: collision_err=%b, required 1", bus.collision_err);
        end
        for (int i = 0; i < 8; i++) tick();
        drive_load(15'h0100);
        tick();
        drive_idle();
        wait_drain();
        n_checks++;
        if (load_q.size() != 0 || bus.collision_err !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_after: loads=%0d collision_err=%b, required 0 1",
                     load_q.size(), bus.collision_err);
        end
    endtask

    task automatic test_reset_midflight();
        tick(); drive_store(15'h0300, 128'hAAAA_1111);
        tick(); drive_load(15'h0300);
        tick(); drive_idle();
        tick();
        tick();
        reset = 1'b1;
        drive_store(15'h0300, 128'hBBBB_2222);
        load_q.delete();
        tick();
        reset = 1'b0;
        drive_idle();
        n_checks++;
        if (bus.load_valid !== 1'b0 || bus.LS_data_output !== 128'h0) begin
            n_fail++;
            $display("FAIL midflight_load: load_valid=%b LS_data_output=%h, required 0 0",
                     bus.load_valid, bus.LS_data_output);
        end
        n_checks++;
        if (bus.collision_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_collision: collision_err=%b, required 0", bus.collision_err);
        end
        for (int i = 0; i < 8; i++) tick();
        drive_load(15'h0300);
        tick();
        drive_idle();
        wait_drain();
        n_checks++;
        if (load_q.size() != 0) begin
            n_fail++;
            $display("FAIL midflight_drain: %0d loads outstanding, required 0", load_q.size());
        end
    endtask

    task automatic test_parallel();
        int n_cyc;
        tick(); drive_store(15'h0500, 128'h1111_2222_3333_4444);
        tick(); drive_store(15'h0600, 128'h9999_8888_7777_6666);
        tick(); drive_load(15'h0500);
        n_cyc = cyc;
        tick(); drive_idle();
        tick();
        tick();
        tick();
        bus.fetch_req     = 1'b1;
        bus.fetch_address = 32'h1234_860C;
        #1;
        n_checks++;
        if (bus.fetch_grant !== 1'b1 || cyc != n_cyc + 4) begin
            n_fail++;
            $display("FAIL parallel_grant: fetch_grant=%b at cycle %0d, required 1 at cycle %0d",
                     bus.fetch_grant, cyc, n_cyc + 4);
        end
        fetch_q.push_back('{data: model_mem[11'h060], due: cyc + FETCH_LAT});
        $display("fetch pc=%h cycle=%0d", bus.fetch_address, cyc);
        tick();
        bus.fetch_req = 1'b0;
        tick();
        n_checks++;
        if (bus.load_valid !== 1'b1 || bus.fetch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL parallel_valids: load_valid=%b fetch_valid=%b at cycle %0d, required 1 1",
                     bus.load_valid, bus.fetch_valid, cyc);
        end
        wait_drain();
        n_checks++;
        if (load_q.size() != 0 || fetch_q.size() != 0) begin
            n_fail++;
            $display("FAIL parallel_drain: loads=%0d fetches=%0d outstanding, required 0 0",
                     load_q.size(), fetch_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_pipelined();
        test_arbitration();
        test_collision();
        test_reset_midflight();
        test_parallel();
        for (int i = 0; i < 4; i++) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
